// File: rtl/updown_seq_pkg.sv
// Shared types and helpers for the up/down target sequencer and its step counter.
package updown_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Prescale timer width; a single-cycle step still needs one bit.
  function automatic int timer_w(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/updown_step_counter.sv
// WIDTH-bit up/down register: load returns it to RESET_VAL, en moves it one count in dir.
module updown_step_counter
  import updown_seq_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 7
) (
  input  logic             clk,
  input  logic             load,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = WIDTH'(RESET_VAL);
    end else if (en) begin
      count_d = (dir == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/updown_target_sequencer.sv
// Drives the step counter toward a commanded target one paced step at a time,
// reporting completion or abort with a one-cycle done pulse.
module updown_target_sequencer
  import updown_seq_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 7,
  parameter int STEP_DIV  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam int TW = timer_w(STEP_DIV);
  localparam logic [TW-1:0] TIMER_MAX = TW'(STEP_DIV - 1);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             step_en;
  logic [WIDTH-1:0] count_next;

  updown_step_counter #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_counter (
    .clk  (clk),
    .load (rst),
    .en   (step_en),
    .dir  (dir_q),
    .count(count)
  );

  // Handshake: a command transfers on any rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high exactly while the FSM is IDLE.
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign dir       = dir_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

  assign count_next = (dir_q == DIR_UP) ? count + WIDTH'(1) : count - WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    timer_d   = timer_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    step_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          target_d = cmd_target;
          timer_d  = '0;
          if (cmd_target == count) begin
            done_d = 1'b1;
          end else begin
            dir_d   = (cmd_target > count) ? DIR_UP : DIR_DOWN;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Abort wins over a step due on the same edge.
        if (abort) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          timer_d   = '0;
        end else if (timer_q == TIMER_MAX) begin
          step_en = 1'b1;
          timer_d = '0;
          if (count_next == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= '0;
      timer_q   <= '0;
      dir_q     <= DIR_UP;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      timer_q   <= timer_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

endmodule
